// File: rtl/spi_exe_master.sv
// SPI initiator: one chip-select frame sends {oper,0,A,B} and then reads back
// the 8-bit result and 4 flag bits (mode 0, MSB first).
module spi_exe_master #(
  parameter int CLK_DIV  = 2,
  parameter int GAP_BITS = 2,
  parameter int RX_BITS  = 12
) (
  input  logic       i_clk_p,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_oper,
  input  logic [7:0] i_argA,
  input  logic [7:0] i_argB,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic [3:0] o_flags,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_cs_n
);

  localparam int TX_BITS  = 24;
  localparam int MAX_BITS = (TX_BITS >= GAP_BITS) ?
                            ((TX_BITS >= RX_BITS) ? TX_BITS : RX_BITS) :
                            ((GAP_BITS >= RX_BITS) ? GAP_BITS : RX_BITS);
  localparam int BW = $clog2(MAX_BITS);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] TX_LAST   = BW'(TX_BITS - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_BITS - 1);
  localparam logic [BW-1:0] RX_LAST   = BW'(RX_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_TX, S_GAP, S_RX, S_CS_HOLD, S_DONE
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_half_cnt;
  logic               r_phase;
  logic [BW-1:0]      r_bit_cnt;
  logic [23:0]        r_tx;
  logic [RX_BITS-1:0] r_rx;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_result;
  logic [3:0]         r_flags;
  logic               r_sclk;
  logic               r_mosi;
  logic               r_cs_n;

  logic w_half_end;
  logic w_bit_last;

  assign w_half_end = (r_half_cnt == HALF_LAST);

  always_comb begin
    w_bit_last = 1'b0;
    case (r_state)
      S_TX:    w_bit_last = (r_bit_cnt == TX_LAST);
      S_GAP:   w_bit_last = (r_bit_cnt == GAP_LAST);
      S_RX:    w_bit_last = (r_bit_cnt == RX_LAST);
      default: w_bit_last = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_half_cnt <= '0;
      r_phase    <= 1'b0;
      r_bit_cnt  <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_CS_SETUP;
            r_busy     <= 1'b1;
            r_cs_n     <= 1'b0;
            r_half_cnt <= '0;
            r_tx       <= {i_oper, 4'b0000, i_argA, i_argB};
          end
        end
        S_CS_SETUP: begin
          if (w_half_end) begin
            // MOSI must already carry the first bit in the first TX cycle.
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
            r_bit_cnt  <= '0;
            r_mosi     <= r_tx[23];
            r_tx       <= {r_tx[22:0], 1'b0};
            r_state    <= S_TX;
          end else begin
            r_half_cnt <= r_half_cnt + CW'(1);
          end
        end
        S_TX, S_GAP, S_RX: begin
          if (!w_half_end) begin
            r_half_cnt <= r_half_cnt + CW'(1);
          end else begin
            r_half_cnt <= '0;
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_sclk  <= 1'b1;
              if (r_state == S_RX) r_rx <= {r_rx[RX_BITS-2:0], i_miso};
            end else begin
              r_phase <= 1'b0;
              r_sclk  <= 1'b0;
              if (!w_bit_last) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
                if (r_state == S_TX) begin
                  r_mosi <= r_tx[23];
                  r_tx   <= {r_tx[22:0], 1'b0};
                end else begin
                  r_mosi <= 1'b0;
                end
              end else begin
                r_bit_cnt <= '0;
                r_mosi    <= 1'b0;
                case (r_state)
                  S_TX:    r_state <= S_GAP;
                  S_GAP:   r_state <= S_RX;
                  default: r_state <= S_CS_HOLD;
                endcase
              end
            end
          end
        end
        S_CS_HOLD: begin
          if (w_half_end) begin
            r_half_cnt <= '0;
            r_cs_n     <= 1'b1;
            r_done     <= 1'b1;
            r_result   <= r_rx[RX_BITS-1 -: 8];
            r_flags    <= r_rx[3:0];
            r_state    <= S_DONE;
          end else begin
            r_half_cnt <= r_half_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // Busy drops one cycle after CS rises, so CS is high at least a clock.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_flags  = r_flags;
  assign o_sclk   = r_sclk;
  assign o_mosi   = r_mosi;
  assign o_cs_n   = r_cs_n;

endmodule
